// File: rtl/aes_pkg.sv
// Shared widths, FSM encodings and payload types for the AES decrypt block loader.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W         = 128;
  localparam int unsigned AES_WORD_W          = 32;
  localparam int unsigned AES_WORDS_PER_BLOCK = 4;
  localparam int unsigned WCNT_W              = 2;

  // Issue FSM encodings (kept as plain constants for legacy tooling)
  localparam logic [0:0] LDR_IDLE = 1'b0;
  localparam logic [0:0] LDR_BUSY = 1'b1;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_WORD_W-1:0]  aes_word_t;

  // One stream beat as seen by the packer
  typedef struct packed {
    aes_word_t data;
    logic      last;
  } aes_beat_t;

  // Insert word number idx into blk; msb_first places word 0 at the top slot.
  // With four words per block, slot 3-idx is simply the bitwise inverse of idx.
  function automatic aes_block_t put_word(input aes_block_t       blk,
                                          input aes_word_t        w,
                                          input logic [WCNT_W-1:0] idx,
                                          input logic             msb_first);
    aes_block_t          r;
    logic [WCNT_W-1:0]   slot;
    r    = blk;
    slot = msb_first ? ~idx : idx;
    r[32'(slot) * AES_WORD_W +: AES_WORD_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/aes_dec_block_loader_if.sv
// Ciphertext word stream between an upstream source and the block loader.
interface aes_dec_block_loader_if;
  import aes_pkg::*;

  aes_word_t s_tdata;
  logic      s_tvalid;
  logic      s_tready;
  logic      s_tlast;

  modport master (
    output s_tdata,
    output s_tvalid,
    output s_tlast,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    input  s_tlast,
    output s_tready
  );

endinterface

// File: rtl/aes_word_packer.sv
// Packs four stream words into a block; holds one finished block when the
// downstream slot cannot take it, and flags tlast arriving mid-block.
module aes_word_packer
  import aes_pkg::*;
#(
  parameter bit WORD_MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  aes_beat_t  beat,
  input  logic       beat_valid,
  output logic       ready,
  input  logic       take,
  output aes_block_t block_c,
  output logic       block_valid_c,
  input  logic       clr_err,
  output logic       err_misaligned
);

  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_d;
  aes_block_t        asm_q;
  aes_block_t        asm_d;
  logic              asm_full;
  logic              asm_full_d;
  logic              err_d;
  logic              ready_d;

  logic accept_c;
  logic last_word_c;
  logic misalign_c;
  logic done_c;

  // Handshake decode and block presentation to the pending slot
  always_comb begin
    accept_c      = beat_valid && ready;
    last_word_c   = (wcnt == WCNT_W'(AES_WORDS_PER_BLOCK - 1));
    misalign_c    = accept_c && beat.last && !last_word_c;
    done_c        = accept_c && last_word_c;
    block_valid_c = asm_full || done_c;
    block_c       = asm_full ? asm_q
                             : put_word(asm_q, beat.data, wcnt, WORD_MSB_FIRST);
  end

  // Next-state for word count, assembly register, hold flag and error
  always_comb begin
    wcnt_d     = wcnt;
    asm_d      = asm_q;
    asm_full_d = asm_full;
    err_d      = err_misaligned;

    if (accept_c) begin
      if (misalign_c) begin
        wcnt_d = '0;
      end else begin
        asm_d  = put_word(asm_q, beat.data, wcnt, WORD_MSB_FIRST);
        wcnt_d = wcnt + WCNT_W'(1);
      end
    end

    // A finished block that the slot could not take is parked here
    if (done_c && !take) begin
      asm_full_d = 1'b1;
    end
    if (asm_full && take) begin
      asm_full_d = 1'b0;
    end

    // A new misalignment wins over a simultaneous clear
    if (misalign_c) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end

    ready_d = !asm_full_d;
  end

  // State registers; ready is held low through reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt           <= '0;
      asm_q          <= '0;
      asm_full       <= 1'b0;
      err_misaligned <= 1'b0;
      ready          <= 1'b0;
    end else begin
      wcnt           <= wcnt_d;
      asm_q          <= asm_d;
      asm_full       <= asm_full_d;
      err_misaligned <= err_d;
      ready          <= ready_d;
    end
  end

endmodule

// File: rtl/aes_dec_block_loader.sv
// Feeds ciphertext blocks to the AES-128 decrypt core: packs the word stream,
// keeps one block pending, issues it with a one-cycle next pulse and counts
// completions signalled by rising edges of block_ready.
module aes_dec_block_loader
  import aes_pkg::*;
#(
  parameter bit          WORD_MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  aes_dec_block_loader_if.slave  s,
  input  logic                   key_ready,
  input  logic                   block_ready,
  output logic                   next,
  output aes_block_t             input_block,
  output logic                   busy,
  output logic [CNT_W-1:0]       blocks_issued,
  output logic                   err_misaligned,
  input  logic                   clr_err
);

  aes_beat_t  beat_c;
  aes_block_t blk_c;
  logic       blk_valid_c;
  logic       take_c;
  logic       issue_c;
  logic       done_edge_c;

  logic [0:0]       state;
  logic [0:0]       state_d;
  aes_block_t       pending_q;
  aes_block_t       pending_d;
  logic             pending_valid;
  logic             pending_valid_d;
  logic             block_ready_q;
  logic             next_d;
  aes_block_t       input_block_d;
  logic             busy_d;
  logic [CNT_W-1:0] blocks_issued_d;

  // Stream beat into the packer
  always_comb begin
    beat_c.data = s.s_tdata;
    beat_c.last = s.s_tlast;
  end

  aes_word_packer #(
    .WORD_MSB_FIRST (WORD_MSB_FIRST)
  ) u_packer (
    .clk            (aclk),
    .rst_n          (aresetn),
    .beat           (beat_c),
    .beat_valid     (s.s_tvalid),
    .ready          (s.s_tready),
    .take           (take_c),
    .block_c        (blk_c),
    .block_valid_c  (blk_valid_c),
    .clr_err        (clr_err),
    .err_misaligned (err_misaligned)
  );

  // Issue and completion conditions; the pending slot also frees on issue
  always_comb begin
    issue_c     = (state == LDR_IDLE) && pending_valid && key_ready;
    done_edge_c = block_ready && !block_ready_q;
    take_c      = blk_valid_c && (!pending_valid || issue_c);
  end

  // Issue FSM next-state, registered outputs and pending slot
  always_comb begin
    state_d         = state;
    next_d          = 1'b0;
    input_block_d   = input_block;
    busy_d          = busy;
    blocks_issued_d = blocks_issued;
    pending_d       = pending_q;
    pending_valid_d = pending_valid;

    case (state)
      LDR_IDLE: begin
        if (issue_c) begin
          next_d          = 1'b1;
          input_block_d   = pending_q;
          pending_valid_d = 1'b0;
          busy_d          = 1'b1;
          state_d         = LDR_BUSY;
        end
      end
      LDR_BUSY: begin
        // A block_ready level left from the previous block has no edge here
        if (done_edge_c) begin
          blocks_issued_d = blocks_issued + CNT_W'(1);
          busy_d          = 1'b0;
          state_d         = LDR_IDLE;
        end
      end
      default: begin
        state_d = LDR_IDLE;
      end
    endcase

    if (take_c) begin
      pending_d       = blk_c;
      pending_valid_d = 1'b1;
    end
  end

  // Loader state registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= LDR_IDLE;
      next          <= 1'b0;
      input_block   <= '0;
      busy          <= 1'b0;
      blocks_issued <= '0;
      pending_q     <= '0;
      pending_valid <= 1'b0;
      block_ready_q <= 1'b0;
    end else begin
      state         <= state_d;
      next          <= next_d;
      input_block   <= input_block_d;
      busy          <= busy_d;
      blocks_issued <= blocks_issued_d;
      pending_q     <= pending_d;
      pending_valid <= pending_valid_d;
      block_ready_q <= block_ready;
    end
  end

endmodule

// File: tb/tb_aes_dec_block_loader.sv
// Directed bench for aes_dec_block_loader with a simple core model. A second
// instance (LSB-first, 2-bit counter) shadows the same stream and core.
module tb_aes_dec_block_loader;
  import aes_pkg::*;

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  logic key_ready = 1'b0;
  logic clr_err   = 1'b0;
  logic block_ready;

  logic             next;
  logic [127:0]     input_block;
  logic             busy;
  logic [15:0]      blocks_issued;
  logic             err_misaligned;

  logic             next2;
  logic [127:0]     input_block2;
  logic             busy2;
  logic [1:0]       blocks_issued2;
  logic             err_misaligned2;

  int compared   = 0;
  int mismatched = 0;

  always #5 aclk = ~aclk;

  aes_dec_block_loader_if ifc ();
  aes_dec_block_loader_if ifc2 ();

  assign ifc2.s_tdata  = ifc.s_tdata;
  assign ifc2.s_tvalid = ifc.s_tvalid;
  assign ifc2.s_tlast  = ifc.s_tlast;

  aes_dec_block_loader #(.WORD_MSB_FIRST(1'b1), .CNT_W(16)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s              (ifc),
    .key_ready      (key_ready),
    .block_ready    (block_ready),
    .next           (next),
    .input_block    (input_block),
    .busy           (busy),
    .blocks_issued  (blocks_issued),
    .err_misaligned (err_misaligned),
    .clr_err        (clr_err)
  );

  aes_dec_block_loader #(.WORD_MSB_FIRST(1'b0), .CNT_W(2)) dut2 (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s              (ifc2),
    .key_ready      (key_ready),
    .block_ready    (block_ready),
    .next           (next2),
    .input_block    (input_block2),
    .busy           (busy2),
    .blocks_issued  (blocks_issued2),
    .err_misaligned (err_misaligned2),
    .clr_err        (clr_err)
  );

  // Core model: block_ready rises core_lat cycles after next, clears on next
  int core_lat = 5;
  int core_cnt;
  bit core_active;
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      block_ready <= 1'b0;
      core_active <= 1'b0;
      core_cnt    <= 0;
    end else if (next) begin
      block_ready <= 1'b0;
      core_active <= 1'b1;
      core_cnt    <= core_lat;
    end else if (core_active) begin
      if (core_cnt <= 1) begin
        block_ready <= 1'b1;
        core_active <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Observers: next pulses, issued blocks, input_block stability, shadow agreement
  int           next_pulses;
  int           stab_viol;
  int           dual_viol;
  logic [127:0] issued_q[$];
  logic         prev_busy;
  logic         prev_next;
  logic [127:0] prev_ib;
  always @(negedge aclk) begin
    if (next === 1'b1) begin
      next_pulses++;
      issued_q.push_back(input_block);
    end
    if (next === 1'b1 && prev_next === 1'b1) stab_viol++;
    if (prev_busy === 1'b1 && busy === 1'b1 && input_block !== prev_ib) stab_viol++;
    if (next2 !== next || busy2 !== busy || ifc2.s_tready !== ifc.s_tready ||
        err_misaligned2 !== err_misaligned) dual_viol++;
    prev_busy = busy;
    prev_next = next;
    prev_ib   = input_block;
  end

  task automatic clear_obs();
    next_pulses = 0;
    stab_viol   = 0;
    dual_viol   = 0;
    issued_q.delete();
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn      = 1'b0;
    ifc.s_tvalid = 1'b0;
    ifc.s_tlast  = 1'b0;
    ifc.s_tdata  = '0;
    clr_err      = 1'b0;
    key_ready    = 1'b1;
    core_lat     = 5;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    clear_obs();
  endtask

  // Present one word at a negedge and return at the negedge after its handshake
  task automatic send_word(input aes_word_t d, input logic l);
    int n = 0;
    ifc.s_tdata  = d;
    ifc.s_tvalid = 1'b1;
    ifc.s_tlast  = l;
    while (ifc.s_tready !== 1'b1 && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 1000) begin
      compared++; mismatched++;
      $display("FAIL send_word_timeout: s_tready=%b, required 1", ifc.s_tready);
    end else begin
      @(negedge aclk);
    end
    ifc.s_tvalid = 1'b0;
    ifc.s_tlast  = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] b);
    for (int j = 0; j < 4; j++) send_word(b[127 - 32*j -: 32], (j == 3));
  endtask

  task automatic wait_issued(input int k);
    int n = 0;
    while (int'(blocks_issued) != k && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    compared++;
    if (n >= 2000) begin
      mismatched++;
      $display("FAIL wait_issued: blocks_issued=%0d, required %0d", blocks_issued, k);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    compared++; if (ifc.s_tready !== 1'b0) begin mismatched++; $display("FAIL reset_tready: got %b want 0", ifc.s_tready); end
    compared++; if (next !== 1'b0) begin mismatched++; $display("FAIL reset_next: got %b want 0", next); end
    compared++; if (input_block !== 128'h0) begin mismatched++; $display("FAIL reset_block: got %h want 0", input_block); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (blocks_issued !== 16'h0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", blocks_issued); end
    compared++; if (err_misaligned !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err_misaligned); end
    repeat (3) @(negedge aclk);
    compared++; if (ifc.s_tready !== 1'b0) begin mismatched++; $display("FAIL reset_tready_held: got %b want 0", ifc.s_tready); end
    aresetn = 1'b1;
    @(negedge aclk);
    compared++; if (ifc.s_tready !== 1'b1) begin mismatched++; $display("FAIL reset_tready_release: got %b want 1", ifc.s_tready); end
  endtask

  task automatic test_single_block();
    do_reset();
    send_word(32'h69c4e0d8, 1'b0);
    send_word(32'h6a7b0430, 1'b0);
    send_word(32'hd8cdb780, 1'b0);
    send_word(32'h70b4c55a, 1'b1);
    compared++; if (next !== 1'b0) begin mismatched++; $display("FAIL single_next_early: got %b want 0", next); end
    @(negedge aclk);
    compared++; if (next !== 1'b1) begin mismatched++; $display("FAIL single_next_rise: got %b want 1", next); end
    compared++; if (input_block !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin mismatched++; $display("FAIL single_block: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", input_block); end
    compared++; if (input_block2 !== 128'h70b4c55ad8cdb7806a7b043069c4e0d8) begin mismatched++; $display("FAIL single_block_lsb_first: got %h want 70b4c55ad8cdb7806a7b043069c4e0d8", input_block2); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge aclk);
    compared++; if (next !== 1'b0) begin mismatched++; $display("FAIL single_next_width: got %b want 0", next); end
    wait_issued(1);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_done_busy: got %b want 0", busy); end
    compared++; if (blocks_issued !== 16'd1) begin mismatched++; $display("FAIL single_count: got %0d want 1", blocks_issued); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk [3] = '{128'h00112233445566778899aabbccddeeff,
                              128'h0f0e0d0c0b0a09080706050403020100,
                              128'hdeadbeefcafef00d0123456789abcdef};
    int ready_hi = 0;
    int n = 0;
    do_reset();
    core_lat = 50;
    for (int b = 0; b < 3; b++) send_block(blk[b]);
    compared++; if (ifc.s_tready !== 1'b0) begin mismatched++; $display("FAIL b2b_stall: s_tready=%b want 0", ifc.s_tready); end
    while (blocks_issued == 16'd0 && n < 500) begin
      if (ifc.s_tready !== 1'b0) ready_hi++;
      @(negedge aclk);
      n++;
    end
    compared++; if (ready_hi != 0) begin mismatched++; $display("FAIL b2b_stall_hold: s_tready high %0d cycles, want 0", ready_hi); end
    wait_issued(3);
    repeat (5) @(negedge aclk);
    compared++; if (next_pulses != 3) begin mismatched++; $display("FAIL b2b_pulses: got %0d want 3", next_pulses); end
    compared++; if (stab_viol != 0) begin mismatched++; $display("FAIL b2b_stable: %0d violations want 0", stab_viol); end
    compared++; if (blocks_issued !== 16'd3) begin mismatched++; $display("FAIL b2b_count: got %0d want 3", blocks_issued); end
    for (int b = 0; b < 3; b++) begin
      compared++; if (issued_q[b] !== blk[b]) begin mismatched++; $display("FAIL b2b_block%0d: got %h want %h", b, issued_q[b], blk[b]); end
    end
    compared++; if (ifc.s_tready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_back: got %b want 1", ifc.s_tready); end
  endtask

  task automatic test_key_gating();
    do_reset();
    key_ready = 1'b0;
    send_block(128'h11111111222222223333333344444444);
    send_block(128'h55555555666666667777777788888888);
    compared++; if (ifc.s_tready !== 1'b0) begin mismatched++; $display("FAIL key_stall: s_tready=%b want 0", ifc.s_tready); end
    repeat (5) @(negedge aclk);
    compared++; if (next_pulses != 0) begin mismatched++; $display("FAIL key_no_issue: %0d pulses want 0", next_pulses); end
    key_ready = 1'b1;
    @(negedge aclk);
    compared++; if (next !== 1'b1) begin mismatched++; $display("FAIL key_issue: next=%b want 1", next); end
    wait_issued(2);
    compared++; if (issued_q[1] !== 128'h55555555666666667777777788888888) begin mismatched++; $display("FAIL key_second_block: got %h want 55555555666666667777777788888888", issued_q[1]); end
  endtask

  task automatic test_misaligned();
    do_reset();
    send_word(32'haaaaaaaa, 1'b0);
    send_word(32'hbbbbbbbb, 1'b1);
    compared++; if (err_misaligned !== 1'b1) begin mismatched++; $display("FAIL mis_err_set: got %b want 1", err_misaligned); end
    repeat (6) @(negedge aclk);
    compared++; if (next_pulses != 0) begin mismatched++; $display("FAIL mis_no_issue: %0d pulses want 0", next_pulses); end
    send_block(128'hc0c0c0c0d1d1d1d1e2e2e2e2f3f3f3f3);
    wait_issued(1);
    compared++; if (issued_q[0] !== 128'hc0c0c0c0d1d1d1d1e2e2e2e2f3f3f3f3) begin mismatched++; $display("FAIL mis_clean_block: got %h want c0c0c0c0d1d1d1d1e2e2e2e2f3f3f3f3", issued_q[0]); end
    compared++; if (err_misaligned !== 1'b1) begin mismatched++; $display("FAIL mis_err_sticky: got %b want 1", err_misaligned); end
    clr_err = 1'b1;
    @(negedge aclk);
    clr_err = 1'b0;
    compared++; if (err_misaligned !== 1'b0) begin mismatched++; $display("FAIL mis_err_clear: got %b want 0", err_misaligned); end
  endtask

  task automatic test_reset_mid_flight();
    do_reset();
    core_lat = 50;
    send_block(128'h0123456789abcdef0011223344556677);
    send_block(128'h99999999888888887777777766666666);
    send_word(32'h12121212, 1'b0);
    send_word(32'h34343434, 1'b0);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2 aresetn = 1'b0;
    #1;
    compared++; if (next !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL mid_ctrl: next=%b busy=%b want 0 0", next, busy); end
    compared++; if (input_block !== 128'h0) begin mismatched++; $display("FAIL mid_block: got %h want 0", input_block); end
    compared++; if (blocks_issued !== 16'h0 || ifc.s_tready !== 1'b0) begin mismatched++; $display("FAIL mid_count_ready: count=%0d ready=%b want 0 0", blocks_issued, ifc.s_tready); end
    repeat (2) @(negedge aclk);
    compared++; if (ifc.s_tready !== 1'b0) begin mismatched++; $display("FAIL mid_ready_held: got %b want 0", ifc.s_tready); end
    aresetn  = 1'b1;
    core_lat = 5;
    @(negedge aclk);
    clear_obs();
    send_block(128'hfedcba98765432100f1e2d3c4b5a6978);
    wait_issued(1);
    repeat (10) @(negedge aclk);
    compared++; if (next_pulses != 1) begin mismatched++; $display("FAIL mid_pulses: got %0d want 1", next_pulses); end
    compared++; if (issued_q[0] !== 128'hfedcba98765432100f1e2d3c4b5a6978) begin mismatched++; $display("FAIL mid_fresh_block: got %h want fedcba98765432100f1e2d3c4b5a6978", issued_q[0]); end
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp_wrap [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [127:0] b;
    do_reset();
    core_lat = 3;
    for (int i = 0; i < 5; i++) begin
      b = {32'h10000000 + 32'(i), 32'h20000000 + 32'(i), 32'h30000000 + 32'(i), 32'h40000000 + 32'(i)};
      send_block(b);
      wait_issued(i + 1);
      compared++; if (blocks_issued2 !== exp_wrap[i]) begin mismatched++; $display("FAIL wrap_count%0d: got %0d want %0d", i, blocks_issued2, exp_wrap[i]); end
    end
    compared++; if (dual_viol != 0) begin mismatched++; $display("FAIL wrap_shadow: %0d disagreements want 0", dual_viol); end
  endtask

  initial begin
    ifc.s_tdata  = '0;
    ifc.s_tvalid = 1'b0;
    ifc.s_tlast  = 1'b0;
    clear_obs();
    test_reset();
    test_single_block();
    test_back_to_back();
    test_key_gating();
    test_misaligned();
    test_reset_mid_flight();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
